turbo_enc_rsc: RTL and testbench

- Parametrised block turbo encoder, successor to the fixed 8-bit XOR-parity encoder.
- Accepts one K-bit block per load handshake.
- Streams one output beat per information bit: systematic bit, parity from RSC encoder 1 (natural order), parity from RSC encoder 2 (interleaved order).
- Supports rate-1/3, or rate-1/2 by alternate-parity puncturing. Sits between the tt wrapper input register and the serial output stage.

---
 rtl/turbo_enc_rsc_pkg.sv | 17 +
 rtl/turbo_enc_rsc_if.sv | 26 ++
 rtl/turbo_enc_rsc_enc.sv | 40 ++++
 rtl/turbo_enc_rsc.sv | 138 +++++++++++++
 tb/tb_turbo_enc_rsc.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/turbo_enc_rsc_pkg.sv
// Shared types and constants for the parametrised turbo encoder.
// Generator polynomials are octal, MSB = current tap, LSB = oldest delay.
package turbo_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ENC  = 1'b1
  } state_t;

  localparam logic [2:0] MASK_R13      = 3'b111;
  localparam logic [2:0] MASK_R12_EVEN = 3'b110;
  localparam logic [2:0] MASK_R12_ODD  = 3'b101;

  localparam logic [2:0] G0 = 3'o7;
  localparam logic [2:0] G1 = 3'o5;

endpackage

// File: rtl/turbo_enc_rsc_if.sv
// Load and beat handshake bundle of the turbo encoder.
// master = block producer / beat consumer, slave = the encoder.
interface turbo_enc_rsc_if #(
  parameter int K = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_data;
  logic         in_rate;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_data;
  logic [2:0]   out_mask;
  logic         out_last;
  logic         busy;

  modport master (
    output in_valid, in_data, in_rate, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, in_rate, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_last, busy
  );
endinterface

// File: rtl/turbo_enc_rsc_enc.sv
// Memory-2 recursive systematic convolutional encoder, state {s1,s0}.
// Parity is combinational from d and state; state advances on step, clears on clr.
module rsc_enc
  import turbo_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       step,
  input  logic       d,
  output logic       parity,
  output logic [1:0] state
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       fb;

  always_comb begin
    fb      = d ^ (G0[1] & state_q[0]) ^ (G0[0] & state_q[1]);
    parity  = (G1[2] & fb) ^ (G1[1] & state_q[0]) ^ (G1[0] & state_q[1]);
    state_d = state_q;
    if (clr) begin
      state_d = 2'b00;
    end else if (step) begin
      state_d = {state_q[0], fb};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 2'b00;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/turbo_enc_rsc.sv
// Block turbo encoder: one K-bit block per load, one {sys,p1,p2} beat per bit, first beat
// the cycle after load; beats hold under out_ready low, ena low freezes all state.
module turbo_enc_rsc
  import turbo_enc_pkg::*;
#(
  parameter int K   = 8,
  parameter int P   = 3,
  parameter int OFF = 0,
  parameter int CW  = $clog2(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  turbo_enc_rsc_if.slave bus
);

  localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);
  localparam logic [CW-1:0] PEN_IDX  = CW'(K - 2);
  localparam logic [CW-1:0] OFF_IDX  = CW'(OFF);
  localparam logic [CW:0]   P_EXT    = (CW + 1)'(P);
  localparam logic [CW:0]   K_EXT    = (CW + 1)'(K);

  state_t        state_q;
  logic [K-1:0]  blk_q;
  logic          rate_q;
  logic [CW-1:0] i_q;
  logic [CW-1:0] j_q;
  logic [CW-1:0] j_d;
  logic [CW:0]   j_sum;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          busy_q;
  logic          load;
  logic          fire;
  logic          d1;
  logic          d2;
  logic          p1;
  logic          p2;
  logic [1:0]    enc1_state_unused;
  logic [1:0]    enc2_state_unused;

  assign load = (state_q == IDLE) & bus.in_valid & ena;
  assign fire = out_valid_q & bus.out_ready & ena;

  // Interleaver address walks j = (OFF + n*P) mod K; P < K keeps one subtract sufficient.
  assign j_sum = {1'b0, j_q} + P_EXT;
  assign j_d   = (j_sum >= K_EXT) ? CW'(j_sum - K_EXT) : j_sum[CW-1:0];

  assign d1 = blk_q[i_q];
  assign d2 = blk_q[j_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      rate_q      <= 1'b0;
      i_q         <= '0;
      j_q         <= OFF_IDX;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            blk_q       <= bus.in_data;
            rate_q      <= bus.in_rate;
            i_q         <= '0;
            j_q         <= OFF_IDX;
            state_q     <= ENC;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ENC: begin
          if (bus.out_ready) begin
            if (i_q == LAST_IDX) begin
              i_q         <= '0;
              j_q         <= OFF_IDX;
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              i_q        <= i_q + 1'b1;
              j_q        <= j_d;
              out_last_q <= (i_q == PEN_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rsc_enc u_enc1 (
    .clk    (clk),
    .rst    (rst),
    .clr    (load),
    .step   (fire),
    .d      (d1),
    .parity (p1),
    .state  (enc1_state_unused)
  );

  rsc_enc u_enc2 (
    .clk    (clk),
    .rst    (rst),
    .clr    (load),
    .step   (fire),
    .d      (d2),
    .parity (p2),
    .state  (enc2_state_unused)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = {d1, p1, p2};

  always_comb begin
    bus.out_mask = 3'b000;
    if (busy_q) begin
      if (!rate_q) begin
        bus.out_mask = MASK_R13;
      end else begin
        bus.out_mask = i_q[0] ? MASK_R12_ODD : MASK_R12_EVEN;
      end
    end
  end

endmodule

// File: tb/tb_turbo_enc_rsc.sv
// Bench for turbo_enc_rsc: scenario tasks compare beats against known vectors and
// against an arithmetic reference model of the turbo code.
module tb_turbo_enc_rsc;
  localparam int K   = 8;
  localparam int P   = 3;
  localparam int OFF = 0;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  turbo_enc_rsc_if #(.K(K)) bus ();

  turbo_enc_rsc #(.K(K), .P(P), .OFF(OFF)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_dat[64];
  logic [2:0] exp_msk[64];
  logic       exp_last[64];
  logic [2:0] got_dat[64];
  logic [2:0] got_msk[64];
  logic       got_last[64];
  int         got_n;

  // Impulse responses of the 7/5 RSC code
  logic [7:0] imp_p1_b0;
  logic [7:0] imp_p1_b3;
  logic [7:0] imp_p2_b3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: two copies of the 1/(1+D+D^2), (1+D^2) recursive code, second one fed in
  // interleaved order (OFF + n*P) mod K.
  task automatic model_block(input logic [K-1:0] d, input bit r);
    int sa0, sa1, sb0, sb1, fa, fb, pa, pb, jj, u, v;
    sa0 = 0; sa1 = 0; sb0 = 0; sb1 = 0;
    for (int k = 0; k < K; k++) begin
      jj = (OFF + k * P) % K;
      u  = int'(d[k]);
      v  = int'(d[jj]);
      fa = (u + sa0 + sa1) % 2;
      pa = (fa + sa1) % 2;
      sa1 = sa0; sa0 = fa;
      fb = (v + sb0 + sb1) % 2;
      pb = (fb + sb1) % 2;
      sb1 = sb0; sb0 = fb;
      exp_dat[k]  = {u[0], pa[0], pb[0]};
      exp_msk[k]  = r ? ((k % 2 == 0) ? 3'b110 : 3'b101) : 3'b111;
      exp_last[k] = (k == K - 1);
    end
  endtask

  task automatic load_block(input logic [K-1:0] d, input bit r, output bit ok);
    ok = 0;
    bus.in_data  = d;
    bus.in_rate  = r;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (bus.in_ready && ena) ok = 1;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int stall_pct, output bit ok);
    ok = 0;
    got_n = 0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
      if (bus.out_valid && bus.out_ready && got_n < 64) begin
        got_dat[got_n]  = bus.out_data;
        got_msk[got_n]  = bus.out_mask;
        got_last[got_n] = bus.out_last;
        got_n++;
        if (bus.out_last) ok = 1;
      end
      tick();
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    repeat (3) tick();
    obs = {bus.in_ready, bus.out_valid, bus.out_data, bus.out_mask, bus.out_last, bus.busy};
    total++;
    if (obs !== 10'b1_0_000_000_0_0) begin
      bad++; $display("FAIL reset_held: got %b want %b", obs, 10'b1_0_000_000_0_0);
    end
    rst = 1'b0;
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== 3'b000) begin bad++; $display("FAIL reset_out_data: got %b want 000", bus.out_data); end
    total++; if (bus.out_mask !== 3'b000) begin bad++; $display("FAIL reset_out_mask: got %b want 000", bus.out_mask); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
  endtask

  // Shared body for the fixed-vector scenarios
  task automatic run_vector(input string name, input logic [K-1:0] d, input bit r,
                            input logic [7:0] p1v, input logic [7:0] p2v);
    bit ok;
    logic [2:0] want_d;
    logic [2:0] want_m;
    load_block(d, r, ok);
    bus.in_rate = ~r;
    bus.in_data = ~d;
    total++;
    if (!ok || bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL %s_first_beat: accepted=%0d vld=%b busy=%b rdy=%b want 1 1 1 0",
                      name, ok, bus.out_valid, bus.busy, bus.in_ready);
    end
    collect(0, ok);
    total++;
    if (!ok || got_n != K) begin
      bad++; $display("FAIL %s_count: got %0d beats want %0d", name, got_n, K);
    end
    for (int k = 0; k < K && k < got_n; k++) begin
      want_d = {d[k], p1v[k], p2v[k]};
      want_m = r ? ((k % 2 == 0) ? 3'b110 : 3'b101) : 3'b111;
      total++;
      if (got_dat[k] !== want_d || got_msk[k] !== want_m || got_last[k] !== (k == K - 1)) begin
        bad++; $display("FAIL %s_beat%0d: got dat=%b msk=%b last=%b want dat=%b msk=%b last=%b",
                        name, k, got_dat[k], got_msk[k], got_last[k], want_d, want_m, k == K - 1);
      end
    end
  endtask

  task automatic test_impulse();
    run_vector("impulse_r13", 8'h01, 1'b0, imp_p1_b0, imp_p1_b0);
  endtask

  task automatic test_interleave();
    run_vector("interleave", 8'h08, 1'b0, imp_p1_b3, imp_p2_b3);
  endtask

  task automatic test_rate_half();
    run_vector("rate_half", 8'h01, 1'b1, imp_p1_b0, imp_p1_b0);
  endtask

  task automatic test_random();
    bit ok;
    logic [K-1:0] d;
    bit r;
    for (int b = 0; b < 6; b++) begin
      d = K'($urandom);
      r = 1'($urandom_range(0, 1));
      model_block(d, r);
      load_block(d, r, ok);
      collect(25, ok);
      total++;
      if (!ok || got_n != K) begin bad++; $display("FAIL random%0d_count: got %0d want %0d", b, got_n, K); end
      for (int k = 0; k < K && k < got_n; k++) begin
        total++;
        if ({got_dat[k], got_msk[k], got_last[k]} !== {exp_dat[k], exp_msk[k], exp_last[k]}) begin
          bad++; $display("FAIL random%0d_beat%0d: got %b/%b/%b want %b/%b/%b", b, k,
                          got_dat[k], got_msk[k], got_last[k], exp_dat[k], exp_msk[k], exp_last[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit done;
    bit stalled;
    logic [2:0] held_d;
    logic [2:0] held_m;
    model_block(8'hA5, 1'b1);
    load_block(8'hA5, 1'b1, ok);
    got_n = 0; done = 0; stalled = 0; held_d = '0; held_m = '0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (stalled) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held_d || bus.out_mask !== held_m) begin
          bad++; $display("FAIL stall_hold: got vld=%b dat=%b msk=%b want 1 %b %b",
                          bus.out_valid, bus.out_data, bus.out_mask, held_d, held_m);
        end
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready && got_n < 64) begin
        got_dat[got_n] = bus.out_data; got_msk[got_n] = bus.out_mask; got_last[got_n] = bus.out_last;
        got_n++;
        if (bus.out_last) done = 1;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held_d  = bus.out_data;
      held_m  = bus.out_mask;
      tick();
    end
    bus.out_ready = 1'b1;
    total++;
    if (!done || got_n != K) begin bad++; $display("FAIL stall_count: got %0d want %0d", got_n, K); end
    for (int k = 0; k < K && k < got_n; k++) begin
      total++;
      if ({got_dat[k], got_msk[k], got_last[k]} !== {exp_dat[k], exp_msk[k], exp_last[k]}) begin
        bad++; $display("FAIL stall_beat%0d: got %b/%b/%b want %b/%b/%b", k,
                        got_dat[k], got_msk[k], got_last[k], exp_dat[k], exp_msk[k], exp_last[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int fires;
    logic [9:0] obs;
    load_block(8'h01, 1'b0, ok);
    fires = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 50 && fires < 4; c++) begin
      if (bus.out_valid) begin
        fires++;
        total++;
        if (bus.out_last !== 1'b0) begin bad++; $display("FAIL abort_last_early: got %b want 0", bus.out_last); end
      end
      tick();
    end
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    obs = {bus.in_ready, bus.out_valid, bus.out_data, bus.out_mask, bus.out_last, bus.busy};
    total++;
    if (fires != 4 || obs !== 10'b1_0_000_000_0_0) begin
      bad++; $display("FAIL abort_reset: fires=%0d got %b want 4 %b", fires, obs, 10'b1_0_000_000_0_0);
    end
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    run_vector("after_abort", 8'h01, 1'b0, imp_p1_b0, imp_p1_b0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit done;
    bit pulsed;
    bit froze;
    logic [K-1:0] d1;
    logic [K-1:0] d2;
    logic [2:0] held_d;
    d1 = K'($urandom);
    d2 = K'($urandom);
    model_block(d1, 1'b0);
    load_block(d1, 1'b0, ok);
    got_n = 0; done = 0; pulsed = 0; froze = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      bus.in_valid = 1'b0;
      if (got_n == 3 && !pulsed) begin
        bus.in_valid = 1'b1; bus.in_data = ~d1; bus.in_rate = 1'b1; pulsed = 1;
      end
      if (got_n == 5 && !froze) begin
        froze  = 1;
        held_d = bus.out_data;
        ena    = 1'b0;
        for (int f = 0; f < 3; f++) begin
          tick();
          total++;
          if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.out_data !== held_d) begin
            bad++; $display("FAIL freeze%0d: got vld=%b busy=%b dat=%b want 1 1 %b",
                            f, bus.out_valid, bus.busy, bus.out_data, held_d);
          end
        end
        ena = 1'b1;
      end
      if (bus.out_valid && got_n < 64) begin
        got_dat[got_n] = bus.out_data; got_msk[got_n] = bus.out_mask; got_last[got_n] = bus.out_last;
        got_n++;
        if (bus.out_last) begin
          done = 1;
          bus.in_valid = 1'b1; bus.in_data = d2; bus.in_rate = 1'b1;
        end
      end
      tick();
    end
    total++;
    if (!done || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL b2b_bubble: done=%0d vld=%b rdy=%b busy=%b want 1 0 1 0",
                      done, bus.out_valid, bus.in_ready, bus.busy);
    end
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_second_load: vld=%b rdy=%b want 1 0", bus.out_valid, bus.in_ready);
    end
    total++;
    if (got_n != K) begin bad++; $display("FAIL b2b_first_count: got %0d want %0d", got_n, K); end
    for (int k = 0; k < K && k < got_n; k++) begin
      total++;
      if ({got_dat[k], got_msk[k], got_last[k]} !== {exp_dat[k], exp_msk[k], exp_last[k]}) begin
        bad++; $display("FAIL b2b_first_beat%0d: got %b/%b/%b want %b/%b/%b", k,
                        got_dat[k], got_msk[k], got_last[k], exp_dat[k], exp_msk[k], exp_last[k]);
      end
    end
    model_block(d2, 1'b1);
    collect(0, ok);
    total++;
    if (!ok || got_n != K) begin bad++; $display("FAIL b2b_second_count: got %0d want %0d", got_n, K); end
    for (int k = 0; k < K && k < got_n; k++) begin
      total++;
      if ({got_dat[k], got_msk[k], got_last[k]} !== {exp_dat[k], exp_msk[k], exp_last[k]}) begin
        bad++; $display("FAIL b2b_second_beat%0d: got %b/%b/%b want %b/%b/%b", k,
                        got_dat[k], got_msk[k], got_last[k], exp_dat[k], exp_msk[k], exp_last[k]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // bit n of each vector is the parity of beat n
    imp_p1_b0 = 8'hB7;   // 1,1,1,0,1,1,0,1
    imp_p1_b3 = 8'hB8;   // 0,0,0,1,1,1,0,1
    imp_p2_b3 = 8'h6E;   // 0,1,1,1,0,1,1,0
    rst           = 1'b1;
    ena           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_rate   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_impulse();
    test_interleave();
    test_rate_half();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
